// File: rtl/nios2_oci_dct_packer_pkg.sv
// Shared constants and state encoding for the OCI DCT trace packer.
// Word = SYM_MAX symbols of SYM_W bits, symbol k at bits [SYM_W*k +: SYM_W].
package nios2_oci_dct_pkg;

  localparam int SYM_W     = 2;
  localparam int SYM_MAX   = 15;
  localparam int DCT_BUF_W = SYM_W * SYM_MAX;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    ENDED
  } dct_state_e;

endpackage

// File: rtl/nios2_oci_dct_packer_if.sv
// Trace symbol input, DCT word output and end-of-test status bundle.
// master = packer side, slave = trace source / DCT sink side.
interface nios2_oci_dct_packer_if;
  import nios2_oci_dct_pkg::*;

  logic                 sym_valid;
  logic [SYM_W-1:0]     sym_data;
  logic                 sym_ready;
  logic                 flush;
  logic                 end_req;
  logic [DCT_BUF_W-1:0] dct_buffer;
  logic [CNT_W-1:0]     dct_count;
  logic                 dct_valid;
  logic                 dct_ready;
  logic                 test_ending;
  logic                 test_has_ended;

  modport master (
    input  sym_valid, sym_data, flush, end_req, dct_ready,
    output sym_ready, dct_buffer, dct_count, dct_valid, test_ending, test_has_ended
  );

  modport slave (
    output sym_valid, sym_data, flush, end_req, dct_ready,
    input  sym_ready, dct_buffer, dct_count, dct_valid, test_ending, test_has_ended
  );

endinterface

// File: rtl/nios2_oci_dct_packer_out_reg.sv
// Single-entry valid/ready holding stage for packed DCT words; load -> valid next cycle.
// Holds data stable while valid && !ready; out_free lets a new word load on the accept cycle.
module nios2_oci_dct_out_reg
  import nios2_oci_dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DCT_BUF_W-1:0] load_buf,
  input  logic [CNT_W-1:0]     load_cnt,
  input  logic                 ready,
  output logic                 valid,
  output logic [DCT_BUF_W-1:0] buffer,
  output logic [CNT_W-1:0]     count,
  output logic                 out_free
);

  assign out_free = !valid || ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid  <= 1'b0;
      buffer <= '0;
      count  <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      buffer <= load_buf;
      count  <= load_cnt;
    end else if (ready) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit trace symbols into 30-bit DCT words; full word valid 2 cycles after 15th symbol.
// sym_ready drops while flushing/draining or when the accumulator is full and the output is blocked.
module nios2_oci_dct_packer
  import nios2_oci_dct_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  nios2_oci_dct_packer_if.master  bus
);

  dct_state_e           state, state_nxt;
  logic [DCT_BUF_W-1:0] acc, acc_nxt, acc_base;
  logic [CNT_W-1:0]     acc_cnt, acc_cnt_nxt, cnt_base;
  logic                 flush_pend, flush_pend_nxt;
  logic                 out_free;
  logic                 accept;
  logic                 transfer;
  logic                 acc_full;
  logic                 acc_empty;

  assign acc_full  = (acc_cnt == CNT_W'(SYM_MAX));
  assign acc_empty = (acc_cnt == '0);

  // Gated by reset so the source sees no acceptance while reset is held.
  assign bus.sym_ready = !reset && (state == RUN) && !flush_pend && (!acc_full || out_free);
  assign accept        = bus.sym_valid && bus.sym_ready;
  assign transfer      = out_free &&
                         (acc_full || ((flush_pend || (state == DRAIN)) && !acc_empty));

  assign bus.test_ending    = (state != RUN);
  assign bus.test_has_ended = (state == ENDED);

  // A symbol arriving with a transfer lands in slot 0 of the freshly cleared accumulator.
  always_comb begin
    acc_base    = transfer ? '0 : acc;
    cnt_base    = transfer ? '0 : acc_cnt;
    acc_nxt     = acc_base;
    acc_cnt_nxt = cnt_base;
    if (accept) begin
      acc_nxt     = acc_base | (DCT_BUF_W'(bus.sym_data) << (SYM_W * cnt_base));
      acc_cnt_nxt = cnt_base + CNT_W'(1);
    end
  end

  always_comb begin
    flush_pend_nxt = flush_pend && !transfer;
    if (bus.flush && (state == RUN)) begin
      flush_pend_nxt = 1'b1;
    end
    if (acc_cnt_nxt == '0) begin
      flush_pend_nxt = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (bus.end_req) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (acc_empty && !bus.dct_valid) begin
          state_nxt = ENDED;
        end
      end
      ENDED: begin
        state_nxt = ENDED;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      acc        <= '0;
      acc_cnt    <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      acc_cnt    <= acc_cnt_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

  nios2_oci_dct_out_reg u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (transfer),
    .load_buf (acc),
    .load_cnt (acc_cnt),
    .ready    (bus.dct_ready),
    .valid    (bus.dct_valid),
    .buffer   (bus.dct_buffer),
    .count    (bus.dct_count),
    .out_free (out_free)
  );

endmodule
